// File: rtl/axi_addr_router_pkg.sv
// Shared types and constants for the address router.
package axi_addr_router_pkg;

  // Router FSM: IDLE while nothing is outstanding, ACTIVE otherwise.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Width of the outstanding-transaction counter.
  localparam int unsigned OUTS_W = 8;

  // Target encoding width: slaves 0..slv_n-1 plus the default slave at index slv_n.
  function automatic int unsigned tgt_w(input int unsigned slv_n);
    return $clog2(slv_n + 1);
  endfunction

endpackage

// File: rtl/axi_addr_slice.sv
// One-entry valid/ready register slice.
module axi_addr_slice #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  logic          full_q;
  logic [DW-1:0] data_q;

  // Space is available when empty or when the held entry leaves this cycle.
  assign in_ready  = !full_q || out_ready;
  assign out_valid = full_q;
  assign out_data  = data_q;

  // Load on accept, drain on downstream handshake; data holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid && in_ready) begin
      full_q <= 1'b1;
      data_q <= in_data;
    end else if (out_ready) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_addr_router.sv
// Address decoder/router with one-entry output slice and outstanding-transaction
// tracking that blocks target switches while responses are pending.
module axi_addr_router
  import axi_addr_router_pkg::*;
#(
  parameter int unsigned                SLV_N      = 8,
  parameter int unsigned                AW         = 32,
  parameter logic [SLV_N-1:0][AW-1:0]   SLV_ADDR_L = '0,
  parameter logic [SLV_N-1:0][AW-1:0]   SLV_ADDR_H = '0,
  parameter logic [SLV_N-1:0]           SLV_ACCESS = '1,
  parameter int unsigned                MAX_OUTS   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [AW-1:0]     i_addr,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [AW-1:0]     o_addr,
  output logic [SLV_N-1:0]  o_sel,
  output logic              o_sel_ds,
  input  logic [SLV_N-1:0]  i_slv_ready,
  input  logic              i_ds_ready,
  input  logic              i_done,
  output logic [OUTS_W-1:0] o_outs,
  output logic              o_err
);

  localparam int unsigned       TW       = tgt_w(SLV_N);
  localparam logic [TW-1:0]     DS       = TW'(SLV_N);
  localparam logic [OUTS_W-1:0] OUTS_MAX = OUTS_W'(MAX_OUTS);

  logic [TW-1:0]     dec_tgt;
  logic              dec_found;
  logic              slc_in_ready;
  logic              slc_valid;
  logic [TW-1:0]     slc_tgt;
  logic              fwd_ready;
  logic              stall;
  logic              accept;
  state_t            state_q, state_d;
  logic [TW-1:0]     cur_tgt_q, cur_tgt_d;
  logic [OUTS_W-1:0] outs_q, outs_d;
  logic              err_q, err_d;

  // Address decode: first (lowest-index) enabled range containing i_addr wins.
  always_comb begin
    dec_tgt   = DS;
    dec_found = 1'b0;
    for (int unsigned i = 0; i < SLV_N; i++) begin
      if (!dec_found && SLV_ACCESS[i] &&
          (i_addr >= SLV_ADDR_L[i]) && (i_addr <= SLV_ADDR_H[i])) begin
        dec_tgt   = TW'(i);
        dec_found = 1'b1;
      end
    end
  end

  // Ready of whichever downstream the held entry targets.
  always_comb begin
    fwd_ready = i_ds_ready;
    for (int unsigned i = 0; i < SLV_N; i++) begin
      if (slc_tgt == TW'(i)) fwd_ready = i_slv_ready[i];
    end
  end

  // One-hot slave select; at most one of o_sel/o_sel_ds since slc_tgt is a single code.
  always_comb begin
    o_sel = '0;
    for (int unsigned i = 0; i < SLV_N; i++) begin
      o_sel[i] = slc_valid && (slc_tgt == TW'(i));
    end
    o_sel_ds = slc_valid && (slc_tgt == DS);
  end

  assign stall   = ((outs_q != '0) && (dec_tgt != cur_tgt_q)) ||
                   ((outs_q == OUTS_MAX) && !i_done);
  assign o_ready = slc_in_ready && !stall && !i_rst;
  assign accept  = i_valid && o_ready;

  axi_addr_slice #(
    .DW (AW + TW)
  ) u_slice (
    .clk       (i_clk),
    .rst       (i_rst),
    .in_valid  (accept),
    .in_data   ({dec_tgt, i_addr}),
    .in_ready  (slc_in_ready),
    .out_valid (slc_valid),
    .out_data  ({slc_tgt, o_addr}),
    .out_ready (fwd_ready)
  );

  // Counter, underflow flag and IDLE/ACTIVE next-state; state tracks count != 0.
  always_comb begin
    outs_d    = outs_q;
    err_d     = err_q;
    state_d   = state_q;
    cur_tgt_d = cur_tgt_q;
    if (accept && !i_done) begin
      outs_d = outs_q + OUTS_W'(1);
    end else if (!accept && i_done && (outs_q != '0)) begin
      outs_d = outs_q - OUTS_W'(1);
    end
    if (i_done && (outs_q == '0)) err_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) cur_tgt_d = dec_tgt;
        if (outs_d != '0) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (outs_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, target, count and error registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cur_tgt_q <= DS;
      outs_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_tgt_q <= cur_tgt_d;
      outs_q    <= outs_d;
      err_q     <= err_d;
    end
  end

  assign o_outs = outs_q;
  assign o_err  = err_q;

endmodule

// File: doc/axi_addr_router.md
AXI_ADDR_ROUTER -- requirements
Module: axi_addr_router

Interface
REQ-001 SHALL have parameter SLV_N, default 8: number of slave ports.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter SLV_ADDR_L[SLV_N], default all zero: inclusive low address per slave.
REQ-004 SHALL have parameter SLV_ADDR_H[SLV_N], default all zero: inclusive high address per slave.
REQ-005 SHALL have parameter SLV_ACCESS[SLV_N-1:0], default all ones: per-slave access enable.
REQ-006 SHALL have parameter MAX_OUTS, default 8: maximum outstanding transactions, range 1..255.
REQ-007 SHALL have port i_clk, input, 1: the single clock; all logic on its rising edge.
REQ-008 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port i_addr, input, AW: upstream address.
REQ-010 SHALL have port i_valid, input, 1: upstream address valid.
REQ-011 SHALL have port o_ready, output, 1: upstream address accepted when i_valid && o_ready.
REQ-012 SHALL have port o_addr, output, AW: registered address to slaves.
REQ-013 SHALL have port o_sel, output, SLV_N: one-hot per-slave valid.
REQ-014 SHALL have port o_sel_ds, output, 1: default-slave valid.
REQ-015 SHALL have port i_slv_ready, input, SLV_N: per-slave ready.
REQ-016 SHALL have port i_ds_ready, input, 1: default-slave ready.
REQ-017 SHALL have port i_done, input, 1: single-cycle pulse, one transaction's response completed upstream.
REQ-018 SHALL have port o_outs, output, 8: current outstanding count.
REQ-019 SHALL have port o_err, output, 1: sticky underflow flag, set by i_done while the outstanding count is 0.

Function
REQ-020 SHALL decode hit[i] = SLV_ACCESS[i] && SLV_ADDR_L[i] <= i_addr <= SLV_ADDR_H[i], with unsigned comparison.
REQ-021 SHALL resolve overlapping hits to the lowest index; the target is the default slave (DS) if no hit.
REQ-022 SHALL register the accepted address and target in a one-entry output slice: 1-cycle latency from accept to o_sel/o_sel_ds.
REQ-023 SHALL hold o_addr, o_sel and o_sel_ds stable while the slice is full and the selected ready is low.
REQ-024 SHALL free the slice on the forward handshake: the selected o_sel bit (or o_sel_ds) and the matching ready are both high.
REQ-025 SHALL drive o_ready = (slice empty OR forward handshake this cycle) AND NOT stall; o_ready SHALL NOT depend on i_valid.
REQ-026 SHALL compute stall = (outs != 0 AND decoded target != cur_tgt) OR (outs == MAX_OUTS AND NOT i_done).
REQ-027 SHALL update the count per cycle: accept alone +1; i_done alone -1; both together, unchanged.
REQ-028 SHALL, on i_done with outs == 0, leave the count at 0 and set o_err; o_err clears only on reset.
REQ-029 SHALL use an FSM with states IDLE (outs == 0) and ACTIVE (outs > 0), state held in a flop.
REQ-030 SHALL transition IDLE->ACTIVE on accept and load cur_tgt with the decoded target.
REQ-031 SHALL transition ACTIVE->IDLE when the count goes 1->0.
REQ-032 SHALL NOT change cur_tgt while in ACTIVE.
REQ-033 SHALL NOT assert more than one of o_sel/o_sel_ds in any cycle.
REQ-034 SHALL count a transaction as outstanding from upstream accept, not from the forward handshake.

Reset
REQ-035 SHALL, while i_rst is high at a clock edge, clear the slice and set o_sel = 0, o_sel_ds = 0, o_addr = 0, o_outs = 0, o_err = 0, state = IDLE, cur_tgt = DS.
REQ-036 SHALL keep o_ready low during reset cycles.
REQ-037 SHALL discard any in-flight slice content and count on reset mid-operation; the first accept after reset starts from IDLE.

Structure
REQ-038 SHALL place in a shared package: the state enum (IDLE/ACTIVE), the target encoding width $clog2(SLV_N+1) with DS = SLV_N, and the outstanding-count width constant.
REQ-039 SHALL instantiate exactly one sub-module, axi_addr_slice (one-entry valid/ready register); decode, FSM and counter stay inline.

Verification
REQ-040 SHALL cover: SLV_N=2, ranges [0x0000,0x0FFF] and [0x1000,0x1FFF], addr 0x1004 with slave 1 ready -> o_sel = 2'b10 one cycle after accept, o_outs = 1.
REQ-041 SHALL cover: ranges overlap at 0x0800, addr 0x0800 -> o_sel = 2'b01.
REQ-042 SHALL cover: addr 0x3000 (no hit) -> o_sel_ds = 1, o_sel = 0.
REQ-043 SHALL cover: outs = 2 targeting slave 0, next addr 0x1000 -> o_ready low until two i_done pulses, then accepted.
REQ-044 SHALL cover: MAX_OUTS = 2, three same-target addresses -> third stalled; when i_done coincides with the third accept, o_outs stays 2.
REQ-045 SHALL cover: i_done with outs = 0 -> o_err = 1 and o_outs stays 0; i_rst asserted with slice full -> next cycle o_sel = 0, o_outs = 0, o_err = 0.
